// File: rtl/bus_xfer_ctrl.sv
// Register-to-register bus transfer controller: sequences driver and capture
// enables through a settle / latch / turnaround cycle and counts completed transfers.
module bus_xfer_ctrl #(
  parameter int CNT_W = 8,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  output logic [NREG-1:0]  reg_oe,
  output logic [NREG-1:0]  reg_ie,
  output logic             ext_oe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    LATCH   = 3'd2,
    RELEASE = 3'd3,
    REJECT  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            op_r;
  logic [1:0]      src_r;
  logic [1:0]      dst_r;
  logic            accept_s;
  logic            ready_s;
  logic [NREG-1:0] oe_s;
  logic [NREG-1:0] ie_s;
  logic            ext_s;
  logic            done_s;
  logic            err_s;

  function automatic logic [NREG-1:0] one_hot(input logic [1:0] idx);
    logic [NREG-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  assign accept_s = (state_r == IDLE) && cmd_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command capture: the transfer in flight only ever sees these copies
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= 1'b0;
      src_r <= 2'd0;
      dst_r <= 2'd0;
    end else if (accept_s) begin
      op_r  <= cmd_op;
      src_r <= cmd_src;
      dst_r <= cmd_dst;
    end else begin
      op_r  <= op_r;
      src_r <= src_r;
      dst_r <= dst_r;
    end
  end

  // Completed-transfer counter, advanced on the turnaround cycle; wraps silently
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= {CNT_W{1'b0}};
    end else if (state_r == RELEASE) begin
      xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      xfer_cnt <= xfer_cnt;
    end
  end

  // Next-state logic and enables decoded from the state register and captured fields
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b0;
    oe_s        = '0;
    ie_s        = '0;
    ext_s       = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (cmd_valid) begin
          if (!cmd_op && (cmd_src == cmd_dst)) begin
            state_nxt_s = REJECT;
          end else begin
            state_nxt_s = DRIVE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (op_r) begin
          ext_s = 1'b1;
        end else begin
          oe_s = one_hot(src_r);
        end
        state_nxt_s = LATCH;
      end
      LATCH: begin
        // Driver unchanged from DRIVE so the capture never sees a switching bus
        if (op_r) begin
          ext_s = 1'b1;
        end else begin
          oe_s = one_hot(src_r);
        end
        ie_s        = one_hot(dst_r);
        state_nxt_s = RELEASE;
      end
      RELEASE: begin
        done_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      REJECT: begin
        err_s       = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output gating: reset silences every output in the cycle it is asserted
  always_comb begin
    if (rst) begin
      cmd_ready = 1'b0;
      reg_oe    = '0;
      reg_ie    = '0;
      ext_oe    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
    end else begin
      cmd_ready = ready_s;
      reg_oe    = oe_s;
      reg_ie    = ie_s;
      ext_oe    = ext_s;
      busy      = (state_r != IDLE);
      done      = done_s;
      err       = err_s;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed and random commands compared
// each cycle against a transfer-timeline reference model.
module tb_bus_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] reg_oe;
  logic [3:0] reg_ie;
  logic       ext_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles elapsed since acceptance (0 = idle) plus the captured command
  int         m_phase = 0;
  bit         m_rej   = 1'b0;
  bit         m_op    = 1'b0;
  int         m_src   = 0;
  int         m_dst   = 0;
  int         m_cnt   = 0;
  logic [4:0] prev_drv = 5'd0;

  bus_xfer_ctrl #(.CNT_W(2), .NREG(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .reg_oe(reg_oe), .reg_ie(reg_ie), .ext_oe(ext_oe), .busy(busy),
    .done(done), .err(err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check this cycle's outputs at mid-low phase, then advance the model at the edge
  task automatic cycle();
    logic       e_ready, e_busy, e_err, e_done, e_ext;
    logic [3:0] e_oe, e_ie;
    logic [4:0] cur_drv;
    bit         xfer;
    #1;
    xfer    = !rst && m_phase != 0 && !m_rej;
    e_ready = !rst && m_phase == 0;
    e_busy  = !rst && m_phase != 0;
    e_err   = !rst && m_phase == 1 && m_rej;
    e_done  = xfer && m_phase == 3;
    e_ext   = xfer && (m_phase == 1 || m_phase == 2) && m_op;
    e_oe    = (xfer && (m_phase == 1 || m_phase == 2) && !m_op) ? (4'b0001 << m_src) : 4'b0000;
    e_ie    = (xfer && m_phase == 2) ? (4'b0001 << m_dst) : 4'b0000;
    chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("err",       32'(err),       32'(e_err));
    chk("done",      32'(done),      32'(e_done));
    chk("ext_oe",    32'(ext_oe),    32'(e_ext));
    chk("reg_oe",    32'(reg_oe),    32'(e_oe));
    chk("reg_ie",    32'(reg_ie),    32'(e_ie));
    chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
    cur_drv = {ext_oe, reg_oe};
    chk("drv_onehot", 32'($countones(cur_drv) <= 1), 32'd1);
    chk("ie_onehot",  32'($countones(reg_ie) <= 1), 32'd1);
    if (reg_ie != 4'b0000) chk("ie_drv_stable", 32'(cur_drv), 32'(prev_drv));
    prev_drv = cur_drv;
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_op    = cmd_op;
        m_src   = int'(cmd_src);
        m_dst   = int'(cmd_dst);
        m_rej   = !cmd_op && (cmd_src == cmd_dst);
        m_phase = 1;
      end
    end else if (m_rej || m_phase == 3) begin
      if (!m_rej) m_cnt = (m_cnt + 1) % 4;
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic op, input logic [1:0] src, input logic [1:0] dst);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
    cycle();
    cmd_valid = 1'b0;
    cmd_src   = ~src;
    cmd_dst   = ~dst;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src = 2'd0; cmd_dst = 2'd1;
    @(negedge clk);
    // reset with a command pending: reset wins, all outputs low
    repeat (2) cycle();
    rst = 1'b0; cmd_valid = 1'b0;
    cycle();

    // MOVE 0->1
    issue(1'b0, 2'd0, 2'd1);
    repeat (4) cycle();
    // LOAD into 3, src field ignored
    issue(1'b1, 2'd2, 2'd3);
    repeat (4) cycle();
    // MOVE 2->2 is rejected
    issue(1'b0, 2'd2, 2'd2);
    repeat (3) cycle();
    // reset in the LATCH cycle aborts the transfer
    issue(1'b0, 2'd3, 2'd0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // back-to-back with cmd_valid held and fields scrambled while busy
    cmd_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      cmd_op  = 1'($urandom_range(0, 1));
      cmd_src = 2'($urandom_range(0, 3));
      cmd_dst = (($urandom_range(0, 3)) == 0) ? cmd_src : 2'($urandom_range(0, 3));
      cycle();
    end

    // fully random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_src   = 2'($urandom_range(0, 3));
      cmd_dst   = (($urandom_range(0, 3)) == 0) ? cmd_src : 2'($urandom_range(0, 3));
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // counter wrap: five transfers from reset give 1,2,3,0,1
    rst = 1'b1; cmd_valid = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 2'd0, 2'(i));
      repeat (3) cycle();
    end
    chk("wrap_final", 32'(xfer_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the completed-transfer counter.
REQ-002 The block SHALL have parameter NREG, default 4, the number of bus registers; it is fixed at 4, and other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  the command is presented.
REQ-006 cmd_ready  output  1  the controller can accept a command.
REQ-007 cmd_op  input  1  0 = MOVE (reg to reg), 1 = LOAD (external source to reg).
REQ-008 cmd_src  input  2  source register index; ignored for LOAD.
REQ-009 cmd_dst  input  2  destination register index.
REQ-010 reg_oe  output  4  one-hot register output-enable; bit i lets register i drive the bus.
REQ-011 reg_ie  output  4  one-hot register input-enable; bit i makes register i capture the bus.
REQ-012 ext_oe  output  1  lets the external source drive the bus.
REQ-013 busy  output  1  high when the FSM is not in IDLE.
REQ-014 done  output  1  one-cycle pulse when a transfer completes.
REQ-015 err  output  1  one-cycle pulse when a command is rejected.
REQ-016 xfer_cnt  output  CNT_W  count of completed transfers.

Function
REQ-017 The FSM SHALL have the states IDLE, DRIVE, LATCH, RELEASE and REJECT.
REQ-018 cmd_ready SHALL equal (state == IDLE); a command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-019 The block SHALL capture op, src and dst into internal registers on acceptance; later input changes SHALL NOT affect a transfer in flight.
REQ-020 An accepted MOVE with src == dst SHALL go to REJECT for one cycle with no enables, then return to IDLE.
REQ-021 REJECT SHALL pulse err for one cycle, produce no done pulse and leave xfer_cnt unchanged.
REQ-022 Any other accepted command SHALL go IDLE -> DRIVE -> LATCH -> RELEASE -> IDLE, with exactly one cycle per state.
REQ-023 In DRIVE, the bus driver SHALL be enabled: reg_oe[src] for MOVE, or ext_oe for LOAD. reg_ie SHALL be 0. This is the bus settle cycle.
REQ-024 In LATCH, the same driver SHALL stay enabled and reg_ie[dst] SHALL be 1; the destination captures at the end of this cycle.
REQ-025 In RELEASE, all enables SHALL be 0 (bus turnaround), done SHALL be 1, and xfer_cnt SHALL increment at the end of this cycle.
REQ-026 Latency: from acceptance at cycle 0, DRIVE is cycle 1, LATCH is cycle 2, done is cycle 3, and the next acceptance is possible at cycle 4.
REQ-027 At most one of reg_oe[3:0] and ext_oe SHALL be high in any cycle, at most one reg_ie bit SHALL be high, and every enable SHALL be 0 in IDLE and REJECT.
REQ-028 reg_ie SHALL never be asserted in the same cycle as a change of driver.
REQ-029 All outputs SHALL be registered or decoded from the state register only, with no combinational path from cmd_* to any enable.
REQ-030 xfer_cnt SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-031 cmd_valid asserted while busy SHALL be ignored; the requester must hold the command until it sees cmd_ready.

Reset
REQ-032 While rst is high at a clock edge, the next state SHALL be IDLE and xfer_cnt SHALL be 0.
REQ-033 Reset SHALL force reg_oe = 0, reg_ie = 0, ext_oe = 0, done = 0, err = 0, busy = 0, and cmd_ready = 0 while rst is high.
REQ-034 Reset mid-transfer SHALL abort the transfer: no done pulse, no reg_ie pulse after the reset edge, and no count.
REQ-035 Reset SHALL have priority over a command accepted in the same cycle.

Verification
REQ-036 MOVE src=0, dst=1 accepted at cycle 0 -> reg_oe=0001 at cycles 1-2, reg_ie=0010 at cycle 2 only, done at cycle 3, xfer_cnt 0->1.
REQ-037 LOAD dst=3 -> ext_oe=1 at cycles 1-2, reg_ie=1000 at cycle 2, reg_oe=0000 throughout, done at cycle 3.
REQ-038 MOVE src=2, dst=2 -> err pulse at cycle 1, all enables 0, no done, xfer_cnt unchanged, cmd_ready high again at cycle 2.
REQ-039 rst asserted in the LATCH cycle -> all enables 0 from the next cycle, no done, xfer_cnt=0, cmd_ready=1 once rst drops.
REQ-040 Back-to-back commands with cmd_valid held high and cmd_* changed during busy -> acceptance every 4 cycles, each transfer uses its captured fields, and the one-hot/no-overlap invariants of REQ-027 hold on every cycle.
REQ-041 With CNT_W=2, perform 5 transfers -> xfer_cnt sequence 1, 2, 3, 0, 1.
